// File: rtl/ram_cache.sv
// ram_cache: captures a USB3 slave-FIFO read burst into a local RAM, then
// replays the first NUM_WREN words with a one-hot load strobe per word so
// the per-channel parameter register bank can pick them up in order.
module ram_cache #(
   parameter int unsigned DEPTH    = 256,
   parameter int unsigned ADDR_W   = 8,
   parameter int unsigned NUM_WREN = 24,
   parameter int unsigned RD_LAT   = 1
) (
   input  logic                wrclock,
   input  logic                rst_n,         // synchronous, active-high
   input  logic [31:0]         data,
   input  logic [3:0]          usb_rd_state,
   input  logic                USB3_FLAGA,
   output logic [31:0]         q,
   output logic [NUM_WREN-1:0] wren_out,
   output logic                busy
);

   localparam int unsigned DATA_W = 32;
   localparam int unsigned CNT_W  = ADDR_W + 1;

   localparam logic [3:0]        RD_STATE_ACTIVE = 4'd6;
   localparam logic [CNT_W-1:0]  CNT_FULL        = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0]  CNT_MIN         = CNT_W'(NUM_WREN);
   localparam logic [ADDR_W-1:0] RD_LAST         = ADDR_W'(NUM_WREN - 1);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] CAPTURE = 2'd1;
   localparam logic [1:0] PLAY    = 2'd2;

   // Capture RAM; contents are not reset
   logic [DATA_W-1:0] mem [DEPTH];

   logic [1:0]          state_q,   state_d;
   logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
   logic [CNT_W-1:0]    count_q,   count_d;
   logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
   logic [RD_LAT-1:0]   cap_dly_q, cap_dly_d;
   logic                cap_prev_q;
   logic                busy_q;
   logic [DATA_W-1:0]   q_q;
   logic [NUM_WREN-1:0] wren_q;

   logic                rd_hit_c;
   logic                cap_en_c;
   logic                mem_we_c;
   logic [ADDR_W-1:0]   mem_wa_c;
   logic                play_en_c;

   // Read engine is moving a word out of the FIFO this cycle
   assign rd_hit_c  = (usb_rd_state == RD_STATE_ACTIVE) && USB3_FLAGA;

   // Delay rd_hit so it lines up with the word on data
   assign cap_dly_d = RD_LAT'({cap_dly_q, rd_hit_c});
   assign cap_en_c  = cap_dly_q[RD_LAT-1];

   // Next-state, RAM write and replay control
   always_comb begin
      state_d   = state_q;
      wr_addr_d = wr_addr_q;
      count_d   = count_q;
      rd_addr_d = rd_addr_q;
      mem_we_c  = 1'b0;
      mem_wa_c  = wr_addr_q;
      play_en_c = 1'b0;

      case (state_q)
         IDLE: begin
            // Only a fresh rising edge opens a frame; a burst still running
            // after a replay is therefore ignored in full.
            if (cap_en_c && !cap_prev_q) begin
               mem_we_c  = 1'b1;
               mem_wa_c  = '0;
               wr_addr_d = ADDR_W'(1);
               count_d   = CNT_W'(1);
               state_d   = CAPTURE;
            end
         end

         CAPTURE: begin
            if (cap_en_c) begin
               // Saturate at DEPTH: excess words are dropped, never wrapped
               if (count_q != CNT_FULL) begin
                  mem_we_c  = 1'b1;
                  mem_wa_c  = wr_addr_q;
                  wr_addr_d = wr_addr_q + ADDR_W'(1);
                  count_d   = count_q + CNT_W'(1);
               end
            end else if (count_q >= CNT_MIN) begin
               rd_addr_d = '0;
               state_d   = PLAY;
            end else begin
               state_d   = IDLE;
            end
         end

         PLAY: begin
            play_en_c = 1'b1;
            rd_addr_d = rd_addr_q + ADDR_W'(1);
            if (rd_addr_q == RD_LAST) begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Control state registers
   always_ff @(posedge wrclock) begin
      if (rst_n) begin
         state_q    <= IDLE;
         wr_addr_q  <= '0;
         count_q    <= '0;
         rd_addr_q  <= '0;
         cap_dly_q  <= '0;
         cap_prev_q <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_addr_q  <= wr_addr_d;
         count_q    <= count_d;
         rd_addr_q  <= rd_addr_d;
         cap_dly_q  <= cap_dly_d;
         cap_prev_q <= cap_en_c;
         busy_q     <= (state_d != IDLE);
      end
   end

   // Capture RAM write port
   always_ff @(posedge wrclock) begin
      if (mem_we_c) begin
         mem[mem_wa_c] <= data;
      end
   end

   // Registered RAM read and strobe; q holds the last replayed word
   always_ff @(posedge wrclock) begin
      if (rst_n) begin
         q_q    <= '0;
         wren_q <= '0;
      end else if (play_en_c) begin
         q_q    <= mem[rd_addr_q];
         wren_q <= NUM_WREN'(1) << rd_addr_q;
      end else begin
         wren_q <= '0;
      end
   end

   assign q        = q_q;
   assign wren_out = wren_q;
   assign busy     = busy_q;

endmodule

// File: tb/tb_ram_cache.sv
// tb_ram_cache: frame-level vectors for ram_cache with a scoreboard of the
// expected replay words, plus sequences for replay overlap and reset.
module tb_ram_cache;

   localparam int unsigned NUM_WREN = 24;

   logic                clk = 1'b0;
   logic                rst_n;
   logic [31:0]         data;
   logic [3:0]          usb_rd_state;
   logic                flaga;
   logic [31:0]         q;
   logic [NUM_WREN-1:0] wren_out;
   logic                busy;

   ram_cache #(
      .DEPTH    (256),
      .ADDR_W   (8),
      .NUM_WREN (NUM_WREN),
      .RD_LAT   (1)
   ) dut (
      .wrclock      (clk),
      .rst_n        (rst_n),
      .data         (data),
      .usb_rd_state (usb_rd_state),
      .USB3_FLAGA   (flaga),
      .q            (q),
      .wren_out     (wren_out),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0]         q;
      logic [NUM_WREN-1:0] wren;
   } exp_t;

   // n: cycles with rd_state=6, f: leading cycles of those with FLAGA=1
   typedef struct {
      int          n;
      int          f;
      logic [31:0] base;
      bit          play;
      bit          busy_seen;
      logic [31:0] q_after;
      int          lat;
   } vec_t;

   exp_t sb_q[$];
   vec_t vecs[8];

   int checks = 0;
   int errors = 0;
   bit prev_strobe = 1'b0;
   bit saw_busy;
   int first_strobe;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h", name, got, exp);
      end
   endtask

   // Pops one expected word per strobe and flags gaps inside a replay
   task automatic monitor();
      exp_t e;
      if (wren_out != '0) begin
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_strobe: got wren=%h q=%h want no strobe", wren_out, q);
         end else begin
            e = sb_q.pop_front();
            check("sb_word", {8'h0, wren_out, q}, {8'h0, e.wren, e.q});
         end
         prev_strobe = 1'b1;
      end else begin
         if (prev_strobe) check("strobe_gap", 64'(sb_q.size() == 0), 64'd1);
         prev_strobe = 1'b0;
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      monitor();
   endtask

   task automatic push_frame(input logic [31:0] base);
      exp_t e;
      for (int i = 0; i < int'(NUM_WREN); i++) begin
         e.q    = base + 32'(i);
         e.wren = NUM_WREN'(1) << i;
         sb_q.push_back(e);
      end
   endtask

   // Word captured on cap_en cycle k is base+k; cap_en trails rd_hit by one
   task automatic run_frame(input int n, input int f, input logic [31:0] base);
      saw_busy = 1'b0;
      for (int j = 0; j <= n; j++) begin
         usb_rd_state = (j < n) ? 4'd6 : 4'd0;
         flaga        = (j < f);
         data         = base + 32'(j) - 32'd1;
         step();
         if (busy) saw_busy = 1'b1;
      end
      usb_rd_state = 4'd0;
      flaga        = 1'b0;
   endtask

   task automatic wait_idle();
      bit done;
      done = 1'b0;
      first_strobe = -1;
      for (int k = 1; k <= 600 && !done; k++) begin
         step();
         if (busy) saw_busy = 1'b1;
         if (first_strobe < 0 && wren_out != '0) first_strobe = k;
         if (!busy && wren_out == '0 && sb_q.size() == 0) done = 1'b1;
      end
      check("idle_timeout", 64'(done), 64'd1);
   endtask

   task automatic wait_strobe(input int idx);
      bit found;
      found = 1'b0;
      for (int k = 0; k < 200 && !found; k++) begin
         step();
         if (wren_out == (NUM_WREN'(1) << idx)) found = 1'b1;
      end
      check("strobe_wait", 64'(found), 64'd1);
   endtask

   initial begin
      vecs[0] = '{n: 30,  f: 30,  base: 32'h000, play: 1'b1, busy_seen: 1'b1, q_after: 32'h017, lat: 2};
      vecs[1] = '{n: 10,  f: 10,  base: 32'h200, play: 1'b0, busy_seen: 1'b1, q_after: 32'h017, lat: -1};
      vecs[2] = '{n: 24,  f: 24,  base: 32'h300, play: 1'b1, busy_seen: 1'b1, q_after: 32'h317, lat: 2};
      vecs[3] = '{n: 30,  f: 0,   base: 32'h400, play: 1'b0, busy_seen: 1'b0, q_after: 32'h317, lat: -1};
      vecs[4] = '{n: 40,  f: 26,  base: 32'h600, play: 1'b1, busy_seen: 1'b1, q_after: 32'h617, lat: -1};
      vecs[5] = '{n: 40,  f: 12,  base: 32'h700, play: 1'b0, busy_seen: 1'b1, q_after: 32'h617, lat: -1};
      vecs[6] = '{n: 300, f: 300, base: 32'h100, play: 1'b1, busy_seen: 1'b1, q_after: 32'h117, lat: 2};
      vecs[7] = '{n: 23,  f: 23,  base: 32'h500, play: 1'b0, busy_seen: 1'b1, q_after: 32'h117, lat: -1};

      // Reset held with rd_hit active
      rst_n        = 1'b1;
      usb_rd_state = 4'd6;
      flaga        = 1'b1;
      data         = 32'hAAAA_AAAA;
      step();
      step();
      check("rst_q", 64'(q), 64'd0);
      check("rst_wren", 64'(wren_out), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      usb_rd_state = 4'd0;
      flaga        = 1'b0;
      rst_n        = 1'b0;
      saw_busy     = 1'b0;
      repeat (5) begin
         step();
         if (busy) saw_busy = 1'b1;
      end
      check("post_rst_busy", 64'(saw_busy), 64'd0);
      check("post_rst_q", 64'(q), 64'd0);

      // Table of frames
      for (int r = 0; r < 8; r++) begin
         if (vecs[r].play) push_frame(vecs[r].base);
         run_frame(vecs[r].n, vecs[r].f, vecs[r].base);
         wait_idle();
         if (vecs[r].lat >= 0) check("latency", 64'(first_strobe), 64'(vecs[r].lat));
         repeat (2) step();
         check("vec_q_after", 64'(q), 64'(vecs[r].q_after));
         check("vec_wren_idle", 64'(wren_out), 64'd0);
         check("vec_busy_idle", 64'(busy), 64'd0);
         check("vec_busy_seen", 64'(saw_busy), 64'(vecs[r].busy_seen));
      end

      // Second burst begins mid-replay: first replay unchanged, burst dropped
      push_frame(32'h800);
      run_frame(30, 30, 32'h800);
      wait_strobe(4);
      run_frame(30, 30, 32'h900);
      wait_idle();
      repeat (3) step();
      check("overlap_q", 64'(q), 64'h817);
      check("overlap_busy", 64'(busy), 64'd0);

      // Reset at replay index 10 stops strobes at once
      push_frame(32'hA00);
      run_frame(30, 30, 32'hA00);
      wait_strobe(10);
      sb_q.delete();
      rst_n = 1'b1;
      step();
      check("midrst_wren", 64'(wren_out), 64'd0);
      check("midrst_q", 64'(q), 64'd0);
      check("midrst_busy", 64'(busy), 64'd0);
      step();
      rst_n = 1'b0;
      repeat (40) step();
      check("after_rst_wren", 64'(wren_out), 64'd0);
      check("after_rst_busy", 64'(busy), 64'd0);
      check("after_rst_q", 64'(q), 64'd0);

      // Clean frame after the aborted replay
      push_frame(32'hB00);
      run_frame(24, 24, 32'hB00);
      wait_idle();
      check("recover_q", 64'(q), 64'hB17);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
